serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: {C_out,S} = A + B + C_in, one bit per clock, LSB first, through one full adder.
// Define SERIAL_ADDER_OFL_EN to build the registered two's-complement overflow flag (otherwise Ofl is 0).
module serial_adder #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         C_out,
    output logic         Ofl
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  s_q;
    logic [CW-1:0] cnt_q;
    logic          carry_q;
    logic          c_out_q;
    logic          busy_q;
    logic          done_q;
`ifdef SERIAL_ADDER_OFL_EN
    logic          ofl_q;
`endif

    logic sum_bit_d;
    logic carry_d;
    logic last_bit;

    // The single full adder works on the bottom bits of the operand shift registers.
    assign sum_bit_d = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_d   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign last_bit  = (cnt_q == CW'(N - 1));

    // NOTE: every register in this block uses <= so all updates see the pre-edge values,
    // which is what lets the full adder read the carry while the same edge overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OFL_EN
            ofl_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= C_in;
                        s_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so bit 0 ends up at S[0] after N shifts.
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    s_q     <= {sum_bit_d, s_q[N-1:1]};
                    carry_q <= carry_d;
                    if (last_bit) begin
                        c_out_q <= carry_d;
`ifdef SERIAL_ADDER_OFL_EN
                        ofl_q   <= carry_q ^ carry_d;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign S     = s_q;
    assign C_out = c_out_q;
`ifdef SERIAL_ADDER_OFL_EN
    assign Ofl   = ofl_q;
`else
    assign Ofl   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random operations
// compared against a plain-arithmetic model of A + B + C_in.
module tb_serial_adder;

    localparam int N = 16;
`ifdef SERIAL_ADDER_OFL_EN
    localparam bit OFL_EN = 1'b1;
`else
    localparam bit OFL_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         C_in;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         C_out;
    logic         Ofl;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] exp_s;
    logic         exp_c;
    logic         exp_o;

    serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .C_in  (C_in),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .C_out (C_out),
        .Ofl   (Ofl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: full-width arithmetic sum; overflow from the operand/result sign rule.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
        logic [N:0] full;
        full  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        exp_s = full[N-1:0];
        exp_c = full[N];
        exp_o = OFL_EN && (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
    endtask

    // Called at a negedge after the accepting edge; returns at the negedge where done is seen.
    task automatic wait_done(input string tag, input int poke_at);
        int k = 0;
        int busy_cycles = 0;
        while (done !== 1'b1 && k < N + 4) begin
            if (busy === 1'b1) busy_cycles++;
            if (k == poke_at) begin
                start = 1'b1;
                A     = N'($urandom);
                B     = N'($urandom);
                C_in  = ~C_in;
            end else if (k == poke_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(k), 32'(N));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(N));
    endtask

    // Drive a start at the current negedge, then follow the operation to its done cycle.
    task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin, input int poke_at);
        start = 1'b1;
        A     = a;
        B     = b;
        C_in  = cin;
        model(a, b, cin);
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, poke_at);
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_busy_in_done"}, 32'(busy), 32'(0));
        check({tag, "_S"}, 32'(S), 32'(exp_s));
        check({tag, "_C_out"}, 32'(C_out), 32'(exp_c));
        check({tag, "_Ofl"}, 32'(Ofl), 32'(exp_o));
    endtask

    // One idle cycle after done: pulse must have ended and results must hold.
    task automatic idle_check(input string tag);
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse_end"}, 32'(done), 32'(0));
        check({tag, "_idle_busy"}, 32'(busy), 32'(0));
        check({tag, "_S_hold"}, 32'(S), 32'(exp_s));
        check({tag, "_C_out_hold"}, 32'(C_out), 32'(exp_c));
        check({tag, "_Ofl_hold"}, 32'(Ofl), 32'(exp_o));
    endtask

    initial begin
        int done_seen;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        C_in  = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_S", 32'(S), 32'(0));
        check("reset_C_out", 32'(C_out), 32'(0));
        check("reset_Ofl", 32'(Ofl), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_start_busy", 32'(busy), 32'(0));
        check("idle_no_start_done", 32'(done), 32'(0));

        do_op("one_plus_one", 16'h0001, 16'h0001, 1'b0, -1);
        idle_check("one_plus_one");
        do_op("wrap_carry", 16'hFFFF, 16'h0001, 1'b0, -1);
        idle_check("wrap_carry");

        // Abort an operation between E8 and E9 with an asynchronous reset pulse.
        start = 1'b1;
        A     = 16'hFFFF;
        B     = 16'h0000;
        C_in  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_busy_before_rst", 32'(busy), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_S", 32'(S), 32'(0));
        check("abort_C_out", 32'(C_out), 32'(0));
        check("abort_Ofl", 32'(Ofl), 32'(0));
        #1 rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("abort_no_done_pulse", 32'(done_seen), 32'(0));
        check("abort_stays_idle", 32'(busy), 32'(0));

        do_op("after_abort", 16'h00FF, 16'h0001, 1'b0, -1);
        idle_check("after_abort");
        do_op("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, -1);
        idle_check("signed_ovf");

        // start re-pulsed at E5 is ignored; start held in DONE chains a second op.
        do_op("ignore_start", 16'h1234, 16'h4321, 1'b1, 4);
        check("ignore_start_S_const", 32'(S), 32'h5556);
        do_op("back_to_back", 16'h0002, 16'h0003, 1'b0, -1);
        check("back_to_back_S_const", 32'(S), 32'h0005);
        idle_check("back_to_back");

        for (int i = 0; i < 24; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            int           poke;
            ra   = N'($urandom);
            rb   = N'($urandom);
            poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 3)) : -1;
            if (i % 6 == 0) ra = {1'b0, {(N-1){1'b1}}};
            if (i % 6 == 1) rb = ~ra;
            do_op($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)), poke);
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rand%0d", i));
        end
        idle_check("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
